// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//   Free-running VGA raster timing generator (640x480 @ 25 MHz by default).
//   Two counters sweep the raster (column fastest); every output is registered
//   and derived from the *next* counter value, so hsync/vsync/active and the
//   strobes always line up with col_count/row_count in the same cycle.
//
// Ports
//   clock        in   pixel clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   enable       in   pixel advance enable; everything holds when low
//   hsync        out  horizontal sync, polarity set by SYNC_ACTIVE_LOW
//   vsync        out  vertical sync, polarity set by SYNC_ACTIVE_LOW
//   active       out  high while (col_count,row_count) is visible
//   col_count    out  current column, 0..TOTAL_COLS-1
//   row_count    out  current row, 0..TOTAL_ROWS-1
//   line_start   out  one-cycle pulse when col_count steps to 0
//   frame_start  out  one-cycle pulse when the counters step to (0,0)
//   frame_count  out  frames started since reset, modulo 256
// ---------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int TOTAL_COLS      = 800,
  parameter int TOTAL_ROWS      = 525,
  parameter int ACTIVE_COLS     = 640,
  parameter int ACTIVE_ROWS     = 480,
  parameter int H_FRONT_PORCH   = 16,
  parameter int H_SYNC_WIDTH    = 96,
  parameter int V_FRONT_PORCH   = 10,
  parameter int V_SYNC_WIDTH    = 2,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic [9:0] col_count,
  output logic [9:0] row_count,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int HS_FIRST = ACTIVE_COLS + H_FRONT_PORCH;
  localparam int HS_LAST  = HS_FIRST + H_SYNC_WIDTH - 1;
  localparam int VS_FIRST = ACTIVE_ROWS + V_FRONT_PORCH;
  localparam int VS_LAST  = VS_FIRST + V_SYNC_WIDTH - 1;

  localparam logic [9:0] COL_LAST = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] ROW_LAST = 10'(TOTAL_ROWS - 1);

  // XOR-ing an "asserted" flag with this gives the pin level; it is also the
  // idle (deasserted) level of both sync outputs.
  localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

  if (HS_FIRST + H_SYNC_WIDTH > TOTAL_COLS) begin : g_bad_htiming
    $error("vga_sync_gen: horizontal active+porch+sync exceeds TOTAL_COLS");
  end
  if (VS_FIRST + V_SYNC_WIDTH > TOTAL_ROWS) begin : g_bad_vtiming
    $error("vga_sync_gen: vertical active+porch+sync exceeds TOTAL_ROWS");
  end
  if (TOTAL_COLS > 1024 || TOTAL_ROWS > 1024) begin : g_bad_size
    $error("vga_sync_gen: TOTAL_COLS/TOTAL_ROWS must fit a 10-bit counter");
  end

  logic       col_wrap;
  logic       frame_wrap;
  logic [9:0] col_nxt;
  logic [9:0] row_nxt;
  logic       hs_on_nxt;
  logic       vs_on_nxt;
  logic       act_nxt;

  // Next raster position and the flags that belong to it.
  always_comb begin
    col_wrap   = (col_count == COL_LAST);
    frame_wrap = col_wrap && (row_count == ROW_LAST);
    col_nxt    = col_wrap ? 10'd0 : col_count + 10'd1;
    row_nxt    = row_count;
    if (col_wrap) begin
      row_nxt = (row_count == ROW_LAST) ? 10'd0 : row_count + 10'd1;
    end
    hs_on_nxt = (int'(col_nxt) >= HS_FIRST) && (int'(col_nxt) <= HS_LAST);
    vs_on_nxt = (int'(row_nxt) >= VS_FIRST) && (int'(row_nxt) <= VS_LAST);
    act_nxt   = (int'(col_nxt) < ACTIVE_COLS) && (int'(row_nxt) < ACTIVE_ROWS);
  end

  // Reset parks the counters on the last pixel so the first enabled edge
  // lands on (0,0) and produces a frame_start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_count   <= COL_LAST;
      row_count   <= ROW_LAST;
      hsync       <= SYNC_IDLE;
      vsync       <= SYNC_IDLE;
      active      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      // Strobes fall on every edge; they only rise on an advancing edge.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (enable) begin
        col_count   <= col_nxt;
        row_count   <= row_nxt;
        hsync       <= hs_on_nxt ^ SYNC_IDLE;
        vsync       <= vs_on_nxt ^ SYNC_IDLE;
        active      <= act_nxt;
        line_start  <= col_wrap;
        frame_start <= frame_wrap;
        if (frame_wrap) begin
          frame_count <= frame_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_gen
//   Scoreboard bench for vga_sync_gen. Two instances share clock, reset and
//   enable: the default 640x480 timing and a shortened 8x4 raster used for
//   frame-level behaviour (frame_count wrap, vsync). For every clock the
//   stimulus pushes the expected outputs of both instances; a monitor pops
//   and compares after each rising edge. Directed counts (active width, hsync
//   width/start, line period, toggled-enable hsync width, async reset) are
//   checked against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_vga_sync_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
    logic [9:0] col;
    logic [9:0] row;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;

  logic       hsync_f, vsync_f, active_f, ls_f, fs_f;
  logic [9:0] col_f, row_f;
  logic [7:0] fc_f;
  logic       hsync_s, vsync_s, active_s, ls_s, fs_s;
  logic [9:0] col_s, row_s;
  logic [7:0] fc_s;

  int n_vec = 0;
  int n_bad = 0;
  int s = 0;   // enabled edges since reset release
  obs_t qf[$];
  obs_t qs[$];

  always #5 clk = ~clk;

  vga_sync_gen dut_full (
    .clock(clk), .reset_n(reset_n), .enable(enable),
    .hsync(hsync_f), .vsync(vsync_f), .active(active_f),
    .col_count(col_f), .row_count(row_f),
    .line_start(ls_f), .frame_start(fs_f), .frame_count(fc_f)
  );

  vga_sync_gen #(
    .TOTAL_COLS(8), .TOTAL_ROWS(4), .ACTIVE_COLS(4), .ACTIVE_ROWS(2),
    .H_FRONT_PORCH(1), .H_SYNC_WIDTH(1), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(1),
    .SYNC_ACTIVE_LOW(1)
  ) dut_small (
    .clock(clk), .reset_n(reset_n), .enable(enable),
    .hsync(hsync_s), .vsync(vsync_s), .active(active_s),
    .col_count(col_s), .row_count(row_s),
    .line_start(ls_s), .frame_start(fs_s), .frame_count(fc_s)
  );

  // Expected outputs after k enabled edges, from raster position arithmetic.
  // hsf/vsf are the first sync column/row (hand-entered per raster).
  function automatic obs_t model(int tc, int tr, int ac, int ar, int hsf,
                                 int hsw, int vsf, int vsw, int k, bit adv);
    obs_t o;
    int pos, c, r;
    if (k == 0) begin
      o.hs = 1'b1; o.vs = 1'b1; o.act = 1'b0;
      o.col = 10'(tc - 1); o.row = 10'(tr - 1);
      o.ls = 1'b0; o.fs = 1'b0; o.fc = 8'd0;
      return o;
    end
    pos = (k - 1) % (tc * tr);
    c = pos % tc;
    r = pos / tc;
    o.col = 10'(c);
    o.row = 10'(r);
    o.act = (c < ac) && (r < ar);
    o.hs  = !((c >= hsf) && (c < hsf + hsw));
    o.vs  = !((r >= vsf) && (r < vsf + vsw));
    o.ls  = adv && (c == 0);
    o.fs  = adv && (pos == 0);
    o.fc  = 8'((((k - 1) / (tc * tr)) + 1) % 256);
    return o;
  endfunction

  task automatic check_obs(string nm, obs_t got, obs_t exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got hs=%b vs=%b act=%b col=%0d row=%0d ls=%b fs=%b fc=%0d required hs=%b vs=%b act=%b col=%0d row=%0d ls=%b fs=%b fc=%0d",
               nm, $time, got.hs, got.vs, got.act, got.col, got.row, got.ls, got.fs, got.fc,
               exp.hs, exp.vs, exp.act, exp.col, exp.row, exp.ls, exp.fs, exp.fc);
    end
  endtask

  task automatic check_val(string nm, int got, int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got %0d required %0d", nm, $time, got, exp);
    end
  endtask

  // One clock: drive inputs on the falling edge, queue the expectation for
  // the coming rising edge, return 1 time unit after that edge.
  task automatic step(bit e, bit rn);
    bit adv;
    @(negedge clk);
    reset_n = rn;
    enable  = e;
    adv = e && rn;
    if (!rn) s = 0;
    else if (e) s++;
    qf.push_back(model(800, 525, 640, 480, 656, 96, 490, 2, s, adv));
    qs.push_back(model(8, 4, 4, 2, 5, 1, 3, 1, s, adv));
    @(posedge clk);
    #1;
  endtask

  // Monitor: the DUTs produce a result every clock.
  always @(posedge clk) begin : monitor
    obs_t ef, es, gf, gs;
    #1;
    if (qf.size() > 0) begin
      ef = qf.pop_front();
      gf = {hsync_f, vsync_f, active_f, col_f, row_f, ls_f, fs_f, fc_f};
      check_obs("full_raster", gf, ef);
    end
    if (qs.size() > 0) begin
      es = qs.pop_front();
      gs = {hsync_s, vsync_s, active_s, col_s, row_s, ls_s, fs_s, fc_s};
      check_obs("small_raster", gs, es);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog t=%0t got no finish required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int cnt_act, cnt_hs, first_hs, last_ls, cnt_t, s0;
    bit seen255, wrapped, e;
    cnt_act = 0; cnt_hs = 0; first_hs = -1; last_ls = -1;
    seen255 = 1'b0; wrapped = 1'b0;

    // Reset state
    repeat (3) step(1'b0, 1'b0);
    check_val("rst_col", int'(col_f), 799);
    check_val("rst_row", int'(row_f), 524);
    check_val("rst_hsync", int'(hsync_f), 1);

    // Continuous enable: first line, line period, small-raster frame wrap
    for (int i = 0; i < 8200; i++) begin
      step(1'b1, 1'b1);
      if (s == 1) begin
        check_val("first_fs", int'(fs_f), 1);
        check_val("first_ls", int'(ls_f), 1);
        check_val("first_fc", int'(fc_f), 1);
        check_val("first_active", int'(active_f), 1);
      end
      if (s == 2) check_val("second_fs", int'(fs_f), 0);
      if (s <= 800) begin
        if (active_f) cnt_act++;
        if (!hsync_f) begin
          cnt_hs++;
          if (first_hs < 0) first_hs = int'(col_f);
        end
      end
      if (ls_f) begin
        if (last_ls >= 0) check_val("line_period", s - last_ls, 800);
        last_ls = s;
      end
      if (fc_s == 8'd255) seen255 = 1'b1;
      if (fs_s && fc_s == 8'd0 && !wrapped) begin
        wrapped = 1'b1;
        check_val("small_wrap_after_255", int'(seen255), 1);
        check_val("small_wrap_edge", s, 8161);
      end
    end
    check_val("line_active_cycles", cnt_act, 640);
    check_val("line_hsync_low_cycles", cnt_hs, 96);
    check_val("hsync_first_col", first_hs, 656);
    check_val("small_wrapped", int'(wrapped), 1);

    // Align to the last column, then toggle enable for one full line
    for (int i = 0; i < 800 && (s % 800) != 0; i++) step(1'b1, 1'b1);
    s0 = s;
    cnt_t = 0;
    for (int i = 0; i < 1600; i++) begin
      e = (i % 2) == 0;
      step(e, 1'b1);
      if (!hsync_f) cnt_t++;
    end
    check_val("toggle_hsync_low_clocks", cnt_t, 192);
    check_val("toggle_col_steps", s - s0, 800);

    // Run to column 700 (inside hsync) and reset between edges
    for (int i = 0; i < 800 && ((s - 1) % 800) != 700; i++) step(1'b1, 1'b1);
    check_val("pre_reset_col", int'(col_f), 700);
    check_val("pre_reset_hsync", int'(hsync_f), 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("async_rst_hsync", int'(hsync_f), 1);
    check_val("async_rst_vsync", int'(vsync_f), 1);
    check_val("async_rst_active", int'(active_f), 0);
    check_val("async_rst_col", int'(col_f), 799);
    check_val("async_rst_row", int'(row_f), 524);
    check_val("async_rst_fc", int'(fc_f), 0);
    repeat (2) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check_val("restart_col", int'(col_f), 0);
    check_val("restart_row", int'(row_f), 0);
    check_val("restart_fs", int'(fs_f), 1);
    check_val("restart_fc", int'(fc_f), 1);
    repeat (5) step(1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b1);

    @(posedge clk);
    #2;
    check_val("queue_drained", qf.size() + qs.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Free-running VGA raster timing generator for 640x480 at a 25 MHz pixel rate.
- Produces HSync/VSync, an active-video flag, column/row counters and frame/line strobes.
- Sits directly upstream of the sync-to-count and test-pattern stages in Top, and is their only timing source.

Parameters:
TOTAL_COLS, 800, pixels per line including blanking
TOTAL_ROWS, 525, lines per frame including blanking
ACTIVE_COLS, 640, visible pixels per line
ACTIVE_ROWS, 480, visible lines per frame
H_FRONT_PORCH, 16, pixels between end of active video and HSync start
H_SYNC_WIDTH, 96, HSync pulse width in pixels
V_FRONT_PORCH, 10, lines between end of active video and VSync start
V_SYNC_WIDTH, 2, VSync pulse width in lines
SYNC_ACTIVE_LOW, 1, 1 = sync pulses drive 0 when asserted; 0 = drive 1

Ports:
clock  input  1  pixel clock; all logic on its rising edge
reset_n  input  1  asynchronous, active-low reset
enable  input  1  pixel advance enable; counters step only when high
hsync  output  1  horizontal sync at the configured polarity
vsync  output  1  vertical sync at the configured polarity
active  output  1  high while (col_count, row_count) is inside the visible area
col_count  output  10  current column, 0..TOTAL_COLS-1
row_count  output  10  current row, 0..TOTAL_ROWS-1
line_start  output  1  one-cycle pulse when col_count steps to 0
frame_start  output  1  one-cycle pulse when the counters step to (0,0)
frame_count  output  8  frames started since reset, wraps modulo 256

Behaviour:
- Single clock domain: clock. Reset is asynchronous, active-low, named reset_n.
- Reset values:
  - col_count = TOTAL_COLS-1, row_count = TOTAL_ROWS-1.
  - active = 0, line_start = 0, frame_start = 0, frame_count = 0.
  - hsync and vsync at their inactive level (1 when SYNC_ACTIVE_LOW=1).
  - The first enabled cycle after reset therefore lands on (0,0) and pulses frame_start.
- All outputs are registered. hsync, vsync, active and the strobes are computed from the next counter value and updated in the same edge, so every output is coherent with col_count/row_count in the same cycle.
- Counter stepping (enable=1):
  - col_count increments; at TOTAL_COLS-1 it wraps to 0.
  - row_count increments only when col wraps; at TOTAL_ROWS-1 it wraps to 0 on the same edge.
- enable=0: counters, hsync, vsync, active and frame_count hold. line_start and frame_start are forced to 0, so strobes are at most one cycle wide and occur only on advancing edges.
- hsync is asserted when col_count is in [ACTIVE_COLS+H_FRONT_PORCH, ACTIVE_COLS+H_FRONT_PORCH+H_SYNC_WIDTH-1]. With defaults this is 656..751.
- vsync is asserted when row_count is in [ACTIVE_ROWS+V_FRONT_PORCH, ACTIVE_ROWS+V_FRONT_PORCH+V_SYNC_WIDTH-1]. With defaults this is 490..491.
- active = (col_count < ACTIVE_COLS) and (row_count < ACTIVE_ROWS).
- line_start is high on the edge where col becomes 0, including at frame start.
- frame_start is high on the edge where both counters become 0.
- frame_count increments on that same edge (255 -> 0), and the new value is visible together with frame_start.
- Elaboration must fail (assertion) if:
  - ACTIVE_COLS+H_FRONT_PORCH+H_SYNC_WIDTH > TOTAL_COLS, or
  - ACTIVE_ROWS+V_FRONT_PORCH+V_SYNC_WIDTH > TOTAL_ROWS, or
  - TOTAL_COLS > 1024 or TOTAL_ROWS > 1024.
- Reset mid-frame: all outputs return to reset values immediately (asynchronously), with no partial sync pulse held. Timing restarts at (0,0) on the first enabled edge after release.
- Counter arithmetic is unsigned 10-bit; no intermediate value exceeds TOTAL-1.

Test Plan:
1. Reset, then enable=1 continuously:
   - first edge gives col=0, row=0, frame_start=1, line_start=1, frame_count=1, active=1, hsync=vsync=1.
   - next edge gives frame_start=0.
2. Horizontal timing over one line:
   - active is high for exactly 640 cycles (cols 0..639).
   - hsync is low for exactly 96 cycles, starting at col 656.
   - line period is 800 cycles; line_start recurs every 800 cycles.
3. Vertical timing over one frame:
   - vsync is low for rows 490..491 (1600 cycles).
   - active is never high for rows >= 480.
   - frame_start period is 420000 cycles.
4. enable toggled 1/0 alternately:
   - counters advance once per two clocks.
   - strobes are one cycle wide and only on enabled edges.
   - hsync low duration doubles to 192 clocks.
5. Run 256 frames (behavioural shortened parameters TOTAL_COLS=8, TOTAL_ROWS=4, ACTIVE 4/2, porches 1, sync widths 1 permitted):
   - frame_count reaches 255, then wraps to 0 with frame_start.
6. Assert reset_n low at col=700, row=300, with hsync low:
   - hsync and vsync go to 1, active=0 and col=799 without waiting for a clock edge.
   - after release, the first enabled edge gives (0,0) with frame_start=1 and frame_count=1.
